// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: compile-time frame format, run-time bit period latched per frame.
// state   | meaning
// S_IDLE  | line high, ready for a word
// S_START | start bit (low)
// S_DATA  | data bits, LSB first
// S_PAR   | parity bit
// S_STOP  | stop bit(s), high
module uart_tx_cfg #(
  parameter int DATA_W           = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int PRESCALE_W       = 16,
  parameter int DEFAULT_PRESCALE = 434
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam logic [3:0] LAST_IDX  = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t                state;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] p_eff;
  logic [3:0]            idx;
  logic [DATA_W-1:0]     shreg;
  logic                  par_bit;

  assign p_eff   = (prescale_i == '0) ? PRESCALE_W'(DEFAULT_PRESCALE) : prescale_i;
  assign ready_o = (state == S_IDLE);

  // idx counts data bits in S_DATA and stop bits in S_STOP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      period  <= '0;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            shreg   <= data_i;
            period  <= p_eff;
            cnt     <= p_eff - PRESCALE_W'(1);
            par_bit <= (PARITY == 1) ? ~^data_i : ^data_i;
            idx     <= '0;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            cnt   <= period - PRESCALE_W'(1);
            tx_o  <= shreg[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt - PRESCALE_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= period - PRESCALE_W'(1);
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (PARITY != 0) begin
                tx_o  <= par_bit;
                state <= S_PAR;
              end else begin
                tx_o  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              idx   <= idx + 4'd1;
              shreg <= shreg >> 1;
              tx_o  <= shreg[1];
            end
          end else begin
            cnt <= cnt - PRESCALE_W'(1);
          end
        end
        S_PAR: begin
          if (cnt == '0) begin
            cnt   <= period - PRESCALE_W'(1);
            tx_o  <= 1'b1;
            state <= S_STOP;
          end else begin
            cnt <= cnt - PRESCALE_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (idx == LAST_STOP) begin
              idx    <= '0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              idx <= idx + 4'd1;
              cnt <= period - PRESCALE_W'(1);
            end
          end else begin
            cnt <= cnt - PRESCALE_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four format variants, line waveform checked by a receiver monitor.
module tb_uart_tx_cfg;

  localparam int PAR[4]   = '{0, 2, 0, 1};
  localparam int STOPS[4] = '{1, 1, 2, 1};

  typedef struct {
    logic [7:0] d;
    int         p;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid, ready, tx, busy, done;
  logic [7:0] data [4];
  logic [15:0] ps [4];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .prescale_i(ps[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .prescale_i(ps[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[2]), .valid_i(valid[2]), .ready_o(ready[2]),
    .prescale_i(ps[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  uart_tx_cfg #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data[3]), .valid_i(valid[3]), .ready_o(ready[3]),
    .prescale_i(ps[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

  function automatic void chk(string name, bit ok, longint act, longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endfunction

  // Expected line level for frame bit position idx: start, data LSB first, optional parity, stops.
  function automatic logic exp_level(int w, logic [7:0] d, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR[w] != 0 && idx == 9) return (PAR[w] == 2) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic mon(input int w);
    exp_t       e;
    int         k, n, nb, bad_i, bad_v;
    bit         aborted;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (tx[w] == 1'b0) begin
        k = cyc;
        if (q[w].size() == 0) begin
          chk($sformatf("unexpected_start_u%0d", w), 1'b0, k, -1);
          continue;
        end
        e = q[w].pop_front();
        chk($sformatf("start_latency_u%0d", w), k == e.acc + 1, k - e.acc, 1);
        nb = 9 + ((PAR[w] != 0) ? 1 : 0) + STOPS[w];
        n = e.p * nb;
        bad_i = -1;
        bad_v = 0;
        aborted = 1'b0;
        rx = '0;
        for (int i = 0; i < n; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            chk($sformatf("reset_abort_line_u%0d", w), tx[w] == 1'b1, tx[w], 1);
            aborted = 1'b1;
            break;
          end
          if (bad_i < 0 && (tx[w] !== exp_level(w, e.d, i / e.p) || busy[w] !== 1'b1 ||
                            ready[w] !== 1'b0 || done[w] !== 1'b0)) begin
            bad_i = i;
            bad_v = {28'd0, tx[w], busy[w], ready[w], done[w]};
          end
          if ((i % e.p) == (e.p / 2) && (i / e.p) >= 1 && (i / e.p) <= 8)
            rx[(i / e.p) - 1] = tx[w];
        end
        if (!aborted) begin
          chk($sformatf("frame_wave_u%0d_idx", w), bad_i < 0, bad_i, -1);
          if (bad_i >= 0)
            chk($sformatf("frame_wave_u%0d_tx_busy_ready_done", w), 1'b0, bad_v, -1);
          chk($sformatf("rx_data_u%0d", w), rx == e.d, rx, e.d);
          @(negedge clk);
          chk($sformatf("done_cycle_u%0d_done_ready_busy_tx", w),
              {done[w], ready[w], busy[w], tx[w]} == 4'b1101,
              {done[w], ready[w], busy[w], tx[w]}, 4'b1101);
        end
      end else begin
        chk($sformatf("idle_u%0d_done_busy_ready", w),
            {done[w], busy[w], ready[w]} == 3'b001, {done[w], busy[w], ready[w]}, 1);
      end
    end
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic [15:0] p,
                      input bit hold, input bit expect_done);
    bit acc = 1'b0;
    @(posedge clk); #1;
    valid[w] = 1'b1;
    data[w]  = d;
    ps[w]    = p;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (ready[w]) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      chk($sformatf("accept_timeout_u%0d", w), 1'b0, 0, 1);
      valid[w] = 1'b0;
      return;
    end
    if (expect_done) chk($sformatf("b2b_accept_in_done_u%0d", w), done[w] == 1'b1, done[w], 1);
    q[w].push_back('{d: d, p: (p == 0) ? 434 : int'(p), acc: cyc});
    if (!hold) begin
      @(posedge clk); #1;
      valid[w] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (busy == 4'b0000 && q[0].size() == 0 && q[1].size() == 0 &&
          q[2].size() == 0 && q[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", ok, ok, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w, nw;
    rst_n = 1'b0;
    valid = '0;
    for (int i = 0; i < 4; i++) begin
      data[i] = '0;
      ps[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_tx", tx == 4'hF, tx, 4'hF);
    chk("reset_busy", busy == 4'h0, busy, 0);
    chk("reset_done", done == 4'h0, done, 0);
    chk("reset_ready", ready == 4'hF, ready, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
    repeat (2) @(posedge clk);

    // 8N1 0xA5 at P=4; even and odd parity 0x07; 8N2 0xFF at P=3; P=1
    send(0, 8'hA5, 16'd4, 1'b0, 1'b0);
    send(1, 8'h07, 16'd4, 1'b0, 1'b0);
    send(3, 8'h07, 16'd4, 1'b0, 1'b0);
    send(2, 8'hFF, 16'd3, 1'b0, 1'b0);
    wait_idle(200);
    send(2, 8'h81, 16'd1, 1'b0, 1'b0);
    send(1, 8'h5E, 16'd1, 1'b0, 1'b0);
    wait_idle(100);

    // back-to-back with valid held high
    send(0, 8'h55, 16'd2, 1'b1, 1'b0);
    send(0, 8'hAA, 16'd2, 1'b0, 1'b1);
    wait_idle(100);

    // default prescale; mid-frame prescale/data changes must not affect the frame
    send(0, 8'h96, 16'd0, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    ps[0]   = 16'd10;
    data[0] = 8'h3F;
    repeat (1000) @(posedge clk);
    #1;
    ps[0]   = 16'd1;
    wait_idle(6000);

    // reset in the middle of data bit 3 of 0x00 at P=4
    send(0, 8'h00, 16'd4, 1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    chk("pre_reset_line_low", tx[0] == 1'b0, tx[0], 0);
    rst_n = 1'b0;
    #1;
    chk("reset_async_tx", tx[0] == 1'b1, tx[0], 1);
    chk("reset_async_busy", busy[0] == 1'b0, busy[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", ready[0] == 1'b1, ready[0], 1);
    chk("post_reset_busy", busy[0] == 1'b0, busy[0], 0);
    send(0, 8'h3C, 16'd4, 1'b0, 1'b0);
    wait_idle(200);

    // random bursts on random instances
    for (int it = 0; it < 16; it++) begin
      w  = int'($urandom_range(0, 3));
      nw = int'($urandom_range(1, 3));
      for (int j = 0; j < nw; j++)
        send(w, 8'($urandom), 16'($urandom_range(1, 6)), j < nw - 1, j > 0);
    end
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got %0d want %0d", cyc, 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter for the ALU datapath. It replaces the fixed 8N1, fixed-baud transmit path. Data width, parity mode and stop-bit count are set at compile time; the bit period is set at run time and latched per frame. A ready/valid input accepts one word per frame, and tx_o drives the board TX pin directly.

Parameters:
DATA_W, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
PRESCALE_W, 16, width of run-time bit-period input
DEFAULT_PRESCALE, 434, bit period in clocks when prescale_i == 0 (50 MHz / 115200)

Ports:
clk_i  input  1  system clock (50 MHz PLL domain)
rst_ni  input  1  asynchronous active-low reset
data_i  input  DATA_W  word to transmit
valid_i  input  1  data_i valid
ready_o  output  1  block can accept a word this cycle
prescale_i  input  PRESCALE_W  clocks per bit; 0 selects DEFAULT_PRESCALE
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset asynchronous on rst_ni low:
  - state = IDLE; tx_o = 1; busy_o = 0; done_o = 0; internal counters = 0.
  - ready_o = 1 once in IDLE.
- Reset mid-frame aborts immediately: tx_o returns high asynchronously and the partial frame is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - ready_o = 1, busy_o = 0, tx_o = 1.
  - Accept when valid_i & ready_o. On acceptance, latch data_i into a shift register and latch the effective period P (prescale_i, or DEFAULT_PRESCALE if prescale_i == 0).
  - Next state is START.
- START: tx_o = 0 for P cycles, then DATA.
- DATA:
  - DATA_W bits, LSB first, each held for P cycles.
  - Then PARITY if PARITY != 0, else STOP.
- PARITY:
  - Even: bit = XOR of data bits. Odd: bit = inverted XOR.
  - Held P cycles, then STOP.
- STOP: tx_o = 1 for STOP_BITS × P cycles.
- Frame completion (last stop cycle elapses):
  - done_o = 1 for exactly one cycle, in the first cycle back in IDLE.
  - ready_o = 1 in that same cycle.
- Bit timing:
  - Down-counter loads P-1 at each bit start and advances the bit when it reaches 0.
  - The first START cycle is the cycle after acceptance.
  - Frame length N = P × (1 + DATA_W + (PARITY != 0) + STOP_BITS) cycles.
  - ready_o returns exactly N cycles after the acceptance cycle.
- busy_o = 1 in every non-IDLE state.
- ready_o = 0 in every non-IDLE state.
- Back-to-back: if valid_i is high in the done_o cycle, the next word is accepted in that cycle. The next start bit follows with no extra idle cycle beyond that one.
- data_i and prescale_i changes mid-frame are ignored; latched values only.
- P = 1 is legal: one clock per bit.
- Outputs are registered: tx_o, busy_o and done_o come from flops. ready_o may be decoded from the state register.

Test Plan:
- 8N1, prescale_i = 4, send 0xA5 → tx_o = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. ready_o returns 40 cycles after acceptance, with done_o high that cycle only.
- PARITY = 2 (even), prescale_i = 4, send 0x07 → parity bit = 1. PARITY = 1 (odd) → parity bit = 0. Frame length 44 cycles.
- STOP_BITS = 2, prescale_i = 3, send 0xFF → start low 3 cycles, then high 30 cycles. done_o at 33 cycles.
- valid_i held high with 0x55 then 0xAA, prescale_i = 2 → second word accepted in the done_o cycle of the first. Only one idle-high cycle precedes the second start bit. The receiver model decodes 0x55, 0xAA.
- prescale_i = 0 → each bit lasts 434 cycles. Changing prescale_i to 10 mid-frame leaves the current frame unaffected.
- rst_ni pulsed low during the DATA bit 3 of 0x00 → tx_o goes high immediately. After release, ready_o = 1 and busy_o = 0, and no done_o pulse occurs. A following 0x3C frame is decoded correctly.
